// File: rtl/sdram_arb_pkg.sv
// Shared encodings for the SDRAM fill arbiter: FSM states, grant codes and default burst length.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_RD_BURST = 3'd2,
        ST_WR_WAIT  = 3'd3,
        ST_WR_DONE  = 3'd4
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_RD0  = 2'b01;
    localparam logic [1:0] GNT_RD1  = 2'b10;

    localparam int BURST_LEN_DEF = 8;

endpackage

// File: rtl/sdram_arb_rd_select.sv
// Picks which cache's fill request to serve. SDRAM_ARB_ROUND_ROBIN_EN selects round-robin,
// otherwise cache 0 has fixed priority over cache 1.
module sdram_arb_rd_select
    import sdram_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    input  logic       rr_last,
`endif
    output logic [1:0] sel
);

    always_comb begin
        sel = GNT_NONE;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        // rr_last names the cache granted last; on a tie the other one wins.
        if (req0 && req1) begin
            sel = rr_last ? GNT_RD0 : GNT_RD1;
        end else if (req0) begin
            sel = GNT_RD0;
        end else if (req1) begin
            sel = GNT_RD1;
        end
`else
        if (req0) begin
            sel = GNT_RD0;
        end else if (req1) begin
            sel = GNT_RD1;
        end
`endif
    end

endmodule

// File: rtl/sdram_fill_arbiter.sv
// Shares one SDRAM controller port between two cache line-fill requesters and a write-through
// writer. Optional macro SDRAM_ARB_ROUND_ROBIN_EN switches cache selection to round-robin.
module sdram_fill_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W     = 26,
    parameter int BURST_LEN  = BURST_LEN_DEF,
    parameter int MAX_WR_RUN = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd0_req,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic              rd0_fill,
    input  logic              rd1_req,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              rd1_fill,
    output logic [15:0]       rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic [1:0]        wr_be,
    output logic              wr_ack,
    output logic              sd_req,
    output logic              sd_we,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [15:0]       sd_wdata,
    output logic [1:0]        sd_be,
    input  logic              sd_ack,
    input  logic              sd_fill,
    input  logic [15:0]       sd_rdata,
    output logic              busy,
    output logic [1:0]        grant
);

    localparam int CNT_W = (BURST_LEN > 2) ? $clog2(BURST_LEN - 1) : 1;
    localparam int RUN_W = $clog2(MAX_WR_RUN + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BURST_LEN - 2);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_WR_RUN);

    arb_state_t        state_q, state_d;
    logic              sd_req_q, sd_req_d;
    logic              sd_we_q, sd_we_d;
    logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
    logic [15:0]       sd_wdata_q, sd_wdata_d;
    logic [1:0]        sd_be_q, sd_be_d;
    logic              wr_ack_q, wr_ack_d;
    logic [1:0]        grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RUN_W-1:0]  wr_run_q, wr_run_d;
    logic [1:0]        rd_sel;
    logic              rd_pend;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic rr_last_q, rr_last_d;
`endif

    sdram_arb_rd_select u_rd_select (
        .req0    (rd0_req),
        .req1    (rd1_req),
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        .rr_last (rr_last_q),
`endif
        .sel     (rd_sel)
    );

    assign rd_pend = rd0_req | rd1_req;

    always_comb begin
        state_d    = state_q;
        sd_req_d   = sd_req_q;
        sd_we_d    = sd_we_q;
        sd_addr_d  = sd_addr_q;
        sd_wdata_d = sd_wdata_q;
        sd_be_d    = sd_be_q;
        wr_ack_d   = 1'b0;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        wr_run_d   = wr_run_q;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        rr_last_d  = rr_last_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // Writes win until MAX_WR_RUN in a row have gone by with a read waiting.
                if (wr_req && ((wr_run_q < RUN_MAX) || !rd_pend)) begin
                    sd_addr_d  = wr_addr;
                    sd_wdata_d = wr_data;
                    sd_be_d    = wr_be;
                    sd_we_d    = 1'b1;
                    sd_req_d   = 1'b1;
                    grant_d    = GNT_NONE;
                    if (wr_run_q != RUN_MAX) begin
                        wr_run_d = wr_run_q + RUN_W'(1);
                    end
                    state_d = ST_WR_WAIT;
                end else if (rd_pend) begin
                    sd_addr_d = (rd_sel == GNT_RD1) ? rd1_addr : rd0_addr;
                    sd_we_d   = 1'b0;
                    sd_req_d  = 1'b1;
                    grant_d   = rd_sel;
                    wr_run_d  = '0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
                    rr_last_d = (rd_sel == GNT_RD1);
`endif
                    state_d   = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (sd_fill) begin
                    sd_req_d = 1'b0;
                    cnt_d    = CNT_LOAD;
                    state_d  = ST_RD_BURST;
                end
            end
            ST_RD_BURST: begin
                if (cnt_q == '0) begin
                    grant_d = GNT_NONE;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WR_WAIT: begin
                if (sd_ack) begin
                    sd_req_d = 1'b0;
                    wr_ack_d = 1'b1;
                    state_d  = ST_WR_DONE;
                end
            end
            ST_WR_DONE: begin
                // Guard cycle: the writer drops wr_req after seeing wr_ack.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sd_req_q   <= 1'b0;
            sd_we_q    <= 1'b0;
            sd_addr_q  <= '0;
            sd_wdata_q <= '0;
            sd_be_q    <= '0;
            wr_ack_q   <= 1'b0;
            grant_q    <= GNT_NONE;
            cnt_q      <= '0;
            wr_run_q   <= '0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            rr_last_q  <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            sd_req_q   <= sd_req_d;
            sd_we_q    <= sd_we_d;
            sd_addr_q  <= sd_addr_d;
            sd_wdata_q <= sd_wdata_d;
            sd_be_q    <= sd_be_d;
            wr_ack_q   <= wr_ack_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            wr_run_q   <= wr_run_d;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            rr_last_q  <= rr_last_d;
`endif
        end
    end

    assign rd0_fill = sd_fill & (state_q == ST_RD_WAIT) & grant_q[0];
    assign rd1_fill = sd_fill & (state_q == ST_RD_WAIT) & grant_q[1];
    assign rd_data  = sd_rdata;
    assign wr_ack   = wr_ack_q;
    assign sd_req   = sd_req_q;
    assign sd_we    = sd_we_q;
    assign sd_addr  = sd_addr_q;
    assign sd_wdata = sd_wdata_q;
    assign sd_be    = sd_be_q;
    assign grant    = grant_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
